// File: rtl/snitch_tcdm_mem_pm.sv
`default_nettype none
// ============================================================================
// Module   : snitch_tcdm_mem_pm
// Brief    : Multi-bank TCDM memory with per-bank power management. Each bank
//            is an SRAM macro plus an output pipeline and an ACTIVE/SLEEP/WAKE
//            controller that parks idle banks in retention.
// Revision : 1.0 - initial release
// ============================================================================
module snitch_tcdm_mem_pm #(
   parameter int unsigned TCDMDepth   = 1024,
   parameter int unsigned DataWidth   = 64,
   parameter int unsigned NumBanks    = 32,
   parameter int unsigned MemLatency  = 1,
   parameter int unsigned IdleCycles  = 16,
   parameter int unsigned WakeCycles  = 4,
   parameter type         sram_cfg_t  = logic,
   parameter type         sram_cfgs_t = logic,
   localparam int unsigned AddrWidth  = $clog2(TCDMDepth),
   localparam int unsigned BeWidth    = DataWidth / 8
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  sram_cfgs_t                     sram_cfgs_i,
   input  logic                           sleep_en_i,
   input  logic [NumBanks-1:0]            mem_req_i,
   output logic [NumBanks-1:0]            mem_gnt_o,
   input  logic [NumBanks*AddrWidth-1:0]  mem_add_i,
   input  logic [NumBanks-1:0]            mem_wen_i,
   input  logic [NumBanks*BeWidth-1:0]    mem_be_i,
   input  logic [NumBanks*DataWidth-1:0]  mem_wdata_i,
   output logic [NumBanks-1:0]            mem_rvalid_o,
   output logic [NumBanks*DataWidth-1:0]  mem_rdata_o,
   output logic [NumBanks-1:0]            bank_sleep_o
);

   localparam int unsigned IdleW        = (IdleCycles > 0) ? $clog2(IdleCycles + 1) : 1;
   localparam logic [IdleW-1:0] IdleMax = IdleW'(IdleCycles);
   localparam logic [7:0] WakeInit      = 8'(WakeCycles);
   localparam bit SleepAllowed          = (IdleCycles != 0);

   typedef enum logic [1:0] {
      ACTIVE = 2'd0,
      SLEEP  = 2'd1,
      WAKE   = 2'd2
   } state_e;

   // The behavioural macro model has no configuration pins; the port is kept
   // so the block drops in where real macros consume sram_cfgs_i.tcdm.
   logic unused_cfg;
   assign unused_cfg = ^sram_cfgs_i;

   for (genvar i = 0; i < NumBanks; i++) begin : g_bank
      state_e                 state_q, state_d;
      logic [IdleW-1:0]       idle_q, idle_d;
      logic [7:0]             wake_q, wake_d;
      logic [MemLatency-1:0]  vld_q;
      logic [DataWidth-1:0]   dat_q [MemLatency];
      logic [DataWidth-1:0]   sram  [TCDMDepth];
      logic                   req, gnt, access, inflight;
      logic [AddrWidth-1:0]   addr;

      assign req      = mem_req_i[i];
      assign addr     = mem_add_i[i*AddrWidth +: AddrWidth];
      assign gnt      = req & (state_q == ACTIVE);
      assign access   = req & gnt;
      assign inflight = |vld_q;

      assign mem_gnt_o[i]                         = gnt;
      assign bank_sleep_o[i]                      = (state_q == SLEEP);
      assign mem_rvalid_o[i]                      = vld_q[MemLatency-1];
      assign mem_rdata_o[i*DataWidth +: DataWidth] = dat_q[MemLatency-1];

      // Power-state register with idle and wake counters.
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            state_q <= ACTIVE;
            idle_q  <= '0;
            wake_q  <= '0;
         end else begin
            state_q <= state_d;
            idle_q  <= idle_d;
            wake_q  <= wake_d;
         end
      end

      // Next-state logic: sleep only when truly quiet, wake on demand or when
      // permission is withdrawn, and always finish a started wake sequence.
      always_comb begin
         state_d = state_q;
         idle_d  = idle_q;
         wake_d  = wake_q;
         unique case (state_q)
            ACTIVE: begin
               if (req || inflight) begin
                  idle_d = '0;
               end else if (idle_q != IdleMax) begin
                  idle_d = idle_q + IdleW'(1);
               end
               if (SleepAllowed && sleep_en_i && !req && !inflight &&
                   (idle_q == IdleMax)) begin
                  state_d = SLEEP;
                  idle_d  = '0;
               end
            end
            SLEEP: begin
               if (req || !sleep_en_i) begin
                  state_d = WAKE;
                  wake_d  = WakeInit;
               end
            end
            WAKE: begin
               wake_d = wake_q - 8'd1;
               if (wake_q == 8'd1) begin
                  state_d = ACTIVE;
                  idle_d  = '0;
               end
            end
            default: begin
               state_d = ACTIVE;
               idle_d  = '0;
            end
         endcase
      end

      // Macro array: byte-masked writes; contents survive sleep and reset.
      always_ff @(posedge clk_i) begin
         if (access && mem_wen_i[i]) begin
            for (int unsigned b = 0; b < BeWidth; b++) begin
               if (mem_be_i[i*BeWidth + b]) begin
                  sram[addr][b*8 +: 8] <= mem_wdata_i[i*DataWidth + b*8 +: 8];
               end
            end
         end
      end

      // Read pipeline: stage 0 is the macro output, later stages shift freely.
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            vld_q <= '0;
            for (int unsigned k = 0; k < MemLatency; k++) begin
               dat_q[k] <= '0;
            end
         end else begin
            vld_q[0] <= access & ~mem_wen_i[i];
            if (access && !mem_wen_i[i]) begin
               dat_q[0] <= sram[addr];
            end
            for (int unsigned k = 1; k < MemLatency; k++) begin
               vld_q[k] <= vld_q[k-1];
               dat_q[k] <= dat_q[k-1];
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_snitch_tcdm_mem_pm.sv
`default_nettype none
// ============================================================================
// Module   : tb_snitch_tcdm_mem_pm
// Brief    : Self-checking bench for snitch_tcdm_mem_pm with a read scoreboard
//            fed from a reference memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_snitch_tcdm_mem_pm;

   localparam int NB    = 4;
   localparam int DW    = 64;
   localparam int DEPTH = 64;
   localparam int AW    = 6;
   localparam int LAT   = 3;

   typedef struct {
      int          bank;
      int          due;
      logic [63:0] data;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             sleep_en;
   logic [NB-1:0]    req, gnt, wen, rvalid, bsleep;
   logic [NB*AW-1:0] add;
   logic [NB*8-1:0]  be;
   logic [NB*DW-1:0] wdata, rdata;

   logic             z_req, z_gnt, z_wen, z_rvalid, z_sleep;
   logic [AW-1:0]    z_add;
   logic [7:0]       z_be;
   logic [DW-1:0]    z_wdata, z_rdata;

   int               errors = 0;
   int               checks = 0;
   int               cyc    = 0;
   exp_t             sbq[$];
   logic [63:0]      model [int];
   int               rv_count [NB];
   logic [NB-1:0]    saw_sleep;

   snitch_tcdm_mem_pm #(
      .TCDMDepth (DEPTH), .DataWidth (DW), .NumBanks (NB),
      .MemLatency(LAT), .IdleCycles(16), .WakeCycles(4)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .sram_cfgs_i (1'b0),
      .sleep_en_i  (sleep_en),
      .mem_req_i   (req),
      .mem_gnt_o   (gnt),
      .mem_add_i   (add),
      .mem_wen_i   (wen),
      .mem_be_i    (be),
      .mem_wdata_i (wdata),
      .mem_rvalid_o(rvalid),
      .mem_rdata_o (rdata),
      .bank_sleep_o(bsleep)
   );

   snitch_tcdm_mem_pm #(
      .TCDMDepth (DEPTH), .DataWidth (DW), .NumBanks (1),
      .MemLatency(1), .IdleCycles(0), .WakeCycles(4)
   ) dut_z (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .sram_cfgs_i (1'b0),
      .sleep_en_i  (sleep_en),
      .mem_req_i   (z_req),
      .mem_gnt_o   (z_gnt),
      .mem_add_i   (z_add),
      .mem_wen_i   (z_wen),
      .mem_be_i    (z_be),
      .mem_wdata_i (z_wdata),
      .mem_rvalid_o(z_rvalid),
      .mem_rdata_o (z_rdata),
      .bank_sleep_o(z_sleep)
   );

   always #5 clk = ~clk;

   // Cycle index; a window is the half period after each rising edge.
   always @(posedge clk) cyc = cyc + 1;

   initial begin
      #200000;
      $display("FAIL timeout: got no finish, want finish before 200000");
      $fatal(1);
   end

   // Scoreboard: record granted accesses, check every rvalid against the model.
   always @(negedge clk) begin
      exp_t        e;
      logic [63:0] w;
      int          key, idx;
      #1;
      if (rst_n) begin
         for (int b = 0; b < NB; b++) begin
            if (bsleep[b]) saw_sleep[b] = 1'b1;
            if (rvalid[b]) begin
               rv_count[b]++;
               checks++;
               idx = -1;
               for (int q = 0; q < sbq.size(); q++) begin
                  if (idx < 0 && sbq[q].bank == b) idx = q;
               end
               if (idx < 0) begin
                  errors++;
                  $display("FAIL rvalid_unexpected bank%0d: got rvalid=1 want 0 (cycle %0d)", b, cyc);
               end else begin
                  e = sbq[idx];
                  sbq.delete(idx);
                  if (rdata[b*DW +: DW] !== e.data || cyc != e.due) begin
                     errors++;
                     $display("FAIL rdata bank%0d: got %h at cycle %0d want %h at cycle %0d",
                              b, rdata[b*DW +: DW], cyc, e.data, e.due);
                  end
               end
            end
            if (req[b] && gnt[b]) begin
               key = b * DEPTH + int'(add[b*AW +: AW]);
               if (wen[b]) begin
                  w = model.exists(key) ? model[key] : 64'h0;
                  for (int k = 0; k < 8; k++) begin
                     if (be[b*8 + k]) w[k*8 +: 8] = wdata[b*DW + k*8 +: 8];
                  end
                  model[key] = w;
               end else begin
                  e.bank = b;
                  e.due  = cyc + LAT;
                  e.data = model.exists(key) ? model[key] : 64'hx;
                  sbq.push_back(e);
               end
            end
         end
      end
   end

   task automatic access(input int b, input logic we, input int a,
                         input logic [7:0] bm, input logic [63:0] d);
      logic [31:0] av;
      av = a;
      @(negedge clk);
      req               = '0;
      req[b]            = 1'b1;
      wen[b]            = we;
      add[b*AW +: AW]   = av[AW-1:0];
      be[b*8 +: 8]      = bm;
      wdata[b*DW +: DW] = d;
      #1;
      checks++;
      if (gnt[b] !== 1'b1) begin
         errors++;
         $display("FAIL grant bank%0d: got %b want 1", b, gnt[b]);
      end
   endtask

   task automatic drain();
      int t = 0;
      while (sbq.size() != 0 && t < 50) begin
         @(negedge clk);
         t++;
      end
      #2;
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d reads pending want 0", sbq.size());
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; sleep_en = 1'b0; req = 4'b1010; wen = '0;
      add = '0; be = '0; wdata = '0; saw_sleep = '0;
      z_req = 1'b0; z_wen = 1'b0; z_add = '0; z_be = '0; z_wdata = '0;
      for (int b = 0; b < NB; b++) rv_count[b] = 0;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (gnt !== req) begin errors++; $display("FAIL rst_gnt: got %b want %b", gnt, req); end
      checks++; if (rvalid !== '0) begin errors++; $display("FAIL rst_rvalid: got %b want 0", rvalid); end
      checks++; if (rdata !== '0) begin errors++; $display("FAIL rst_rdata: got %h want 0", rdata); end
      checks++; if (bsleep !== '0) begin errors++; $display("FAIL rst_sleep: got %b want 0", bsleep); end
      req = '0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (gnt !== '0 || rvalid !== '0 || rdata !== '0 || bsleep !== '0) begin
         errors++;
         $display("FAIL post_rst: got gnt=%b rvalid=%b sleep=%b want all 0", gnt, rvalid, bsleep);
      end
   endtask

   task automatic test_write_read();
      access(3, 1'b1, 5, 8'hFF, 64'hDEAD_BEEF_0123_4567);
      access(3, 1'b0, 5, 8'h00, 64'h0);
      for (int n = 1; n <= LAT; n++) begin
         @(negedge clk);
         req = '0;
         #1;
         checks++;
         if (rvalid[3] !== (n == LAT)) begin
            errors++;
            $display("FAIL read_latency n=%0d: got rvalid=%b want %b", n, rvalid[3], (n == LAT));
         end
      end
      checks++;
      if (rdata[3*DW +: DW] !== 64'hDEAD_BEEF_0123_4567) begin
         errors++;
         $display("FAIL read_data: got %h want deadbeef01234567", rdata[3*DW +: DW]);
      end
      drain();
   endtask

   task automatic test_byte_mask();
      access(0, 1'b1, 9, 8'hFF, 64'h0);
      access(0, 1'b1, 9, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF);
      access(0, 1'b0, 9, 8'h00, 64'h0);
      @(negedge clk);
      req = '0;
      repeat (LAT - 1) @(negedge clk);
      #1;
      checks++;
      if (rvalid[0] !== 1'b1 || rdata[0 +: DW] !== 64'h0000_0000_FFFF_FFFF) begin
         errors++;
         $display("FAIL byte_mask: got rvalid=%b data=%h want 1 00000000ffffffff", rvalid[0], rdata[0 +: DW]);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 8; k++) access(2, 1'b1, k, 8'hFF, 64'hA5A5_0000_0000_0000 | 64'(k * 17));
      sleep_en = 1'b1;
      rv_count[2] = 0;
      saw_sleep[2] = 1'b0;
      for (int k = 0; k < 8; k++) access(2, 1'b0, k, 8'h00, 64'h0);
      @(negedge clk);
      req = '0;
      drain();
      checks++;
      if (rv_count[2] != 8) begin
         errors++;
         $display("FAIL b2b_count: got %0d want 8", rv_count[2]);
      end
      checks++;
      if (saw_sleep[2] !== 1'b0) begin
         errors++;
         $display("FAIL b2b_sleep: got sleep entry want none");
      end
      sleep_en = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic test_sleep_wake();
      int n;
      access(0, 1'b0, 9, 8'h00, 64'h0);
      n = 0;
      for (int t = 1; t <= 40 && n == 0; t++) begin
         @(negedge clk);
         if (t == 1) begin req = '0; sleep_en = 1'b1; end
         #1;
         if (bsleep[0]) n = t;
      end
      checks++;
      if (n < 20 || n > 22) begin
         errors++;
         $display("FAIL sleep_entry: got %0d windows want 20..22", n);
      end
      @(negedge clk);
      req[0] = 1'b1; wen[0] = 1'b0; add[0 +: AW] = 6'd9;
      #1;
      checks++;
      if (gnt[0] !== 1'b0 || bsleep[0] !== 1'b1) begin
         errors++;
         $display("FAIL sleep_gnt: got gnt=%b sleep=%b want 0 1", gnt[0], bsleep[0]);
      end
      n = 0;
      for (int t = 1; t <= 10 && n == 0; t++) begin
         @(negedge clk);
         #1;
         if (gnt[0]) n = t;
      end
      checks++;
      if (n != 5) begin
         errors++;
         $display("FAIL wake_latency: got %0d want 5", n);
      end
      @(negedge clk);
      req = '0;
      drain();
   endtask

   task automatic test_sleep_en_drop();
      int t = 0;
      while (!bsleep[0] && t < 40) begin
         @(negedge clk);
         #1;
         t++;
      end
      @(negedge clk);
      sleep_en = 1'b0;
      #1;
      checks++;
      if (bsleep !== 4'hF) begin errors++; $display("FAIL drop_w0: got %b want 1111", bsleep); end
      @(negedge clk);
      #1;
      checks++;
      if (bsleep !== 4'h0) begin errors++; $display("FAIL drop_w1: got %b want 0000", bsleep); end
      @(negedge clk);
      req[2] = 1'b1; wen[2] = 1'b0; add[2*AW +: AW] = 6'd0;
      #1;
      checks++;
      if (gnt[2] !== 1'b0) begin errors++; $display("FAIL wake_gnt: got %b want 0", gnt[2]); end
      @(negedge clk);
      req = '0; sleep_en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      req[2] = 1'b1;
      #1;
      checks++;
      if (gnt[2] !== 1'b1 || bsleep !== 4'h0) begin
         errors++;
         $display("FAIL drop_active: got gnt=%b sleep=%b want 1 0000", gnt[2], bsleep);
      end
      @(negedge clk);
      req = '0; sleep_en = 1'b0;
      drain();
      repeat (8) @(negedge clk);
   endtask

   task automatic test_idle_zero();
      logic slept = 1'b0;
      sleep_en = 1'b1;
      repeat (40) begin
         @(negedge clk);
         #1;
         if (z_sleep !== 1'b0) slept = 1'b1;
      end
      checks++;
      if (slept) begin errors++; $display("FAIL idle_zero: got sleep=1 want never"); end
      @(negedge clk);
      z_req = 1'b1; z_wen = 1'b1; z_add = 6'd3; z_be = 8'hFF; z_wdata = 64'h0000_0000_00C0_FFEE;
      @(negedge clk);
      z_wen = 1'b0;
      @(negedge clk);
      z_req = 1'b0;
      #1;
      checks++;
      if (z_rvalid !== 1'b1 || z_rdata !== 64'h0000_0000_00C0_FFEE) begin
         errors++;
         $display("FAIL lat1_read: got rvalid=%b data=%h want 1 c0ffee", z_rvalid, z_rdata);
      end
      sleep_en = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic test_reset_inflight();
      logic seen = 1'b0;
      access(2, 1'b0, 0, 8'h00, 64'h0);
      access(2, 1'b0, 1, 8'h00, 64'h0);
      @(negedge clk);
      rst_n = 1'b0;
      req   = 4'b0101;
      sbq.delete();
      #1;
      checks++;
      if (gnt !== req || rvalid !== '0 || rdata !== '0 || bsleep !== '0) begin
         errors++;
         $display("FAIL inflight_rst: got gnt=%b rvalid=%b sleep=%b want %b 0 0", gnt, rvalid, bsleep, req);
      end
      @(negedge clk);
      req = '0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) begin
         @(negedge clk);
         #1;
         if (rvalid !== '0) seen = 1'b1;
      end
      checks++;
      if (seen) begin errors++; $display("FAIL inflight_rvalid: got rvalid after reset want none"); end
      checks++;
      if (rdata !== '0 || bsleep !== '0 || gnt !== '0) begin
         errors++;
         $display("FAIL inflight_outputs: got rdata=%h sleep=%b want 0 0", rdata, bsleep);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_byte_mask();
      test_back_to_back();
      test_sleep_wake();
      test_sleep_en_drop();
      test_idle_zero();
      test_reset_inflight();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/snitch_tcdm_mem_pm.md
SNITCH_TCDM_MEM_PM -- requirements
Module: snitch_tcdm_mem_pm

Interface
REQ-001 SHALL have parameter TCDMDepth, default 1024, words per bank.
REQ-002 SHALL have parameter DataWidth, default 64, bank word width in bits; must be a multiple of 8.
REQ-003 SHALL have parameter NumBanks, default 32, number of independent banks.
REQ-004 SHALL have parameter MemLatency, default 1, grant-to-rvalid cycles; legal range 1..4; the SRAM macro supplies 1 cycle and MemLatency-1 output register stages supply the rest.
REQ-005 SHALL have parameter IdleCycles, default 16, consecutive idle cycles before a bank sleeps; 0 disables sleep.
REQ-006 SHALL have parameter WakeCycles, default 4, cycles spent in WAKE; legal range 1..255.
REQ-007 SHALL have type parameters sram_cfg_t and sram_cfgs_t, default logic, macro configuration types; the field tcdm of sram_cfgs_t drives every macro.
REQ-008 SHALL have port clk_i, input, 1 bit, the single clock.
REQ-009 SHALL have port rst_ni, input, 1 bit, asynchronous active-low reset.
REQ-010 SHALL have port sram_cfgs_i, input, sram_cfgs_t, macro configuration.
REQ-011 SHALL have port sleep_en_i, input, 1 bit, global sleep permission.
REQ-012 SHALL have port mem_req_i, input, NumBanks bits, per-bank request.
REQ-013 SHALL have port mem_gnt_o, output, NumBanks bits, per-bank grant.
REQ-014 SHALL have port mem_add_i, input, NumBanks x clog2(TCDMDepth) bits, word address.
REQ-015 SHALL have port mem_wen_i, input, NumBanks bits, 1 = write, 0 = read.
REQ-016 SHALL have port mem_be_i, input, NumBanks x DataWidth/8 bits, byte enables.
REQ-017 SHALL have port mem_wdata_i, input, NumBanks x DataWidth bits, write data.
REQ-018 SHALL have port mem_rvalid_o, output, NumBanks bits, read data valid.
REQ-019 SHALL have port mem_rdata_o, output, NumBanks x DataWidth bits, read data.
REQ-020 SHALL have port bank_sleep_o, output, NumBanks bits, 1 while a bank is in SLEEP, for power-intent control.

Function
REQ-021 SHALL run an independent three-state FSM per bank: ACTIVE, SLEEP and WAKE.
REQ-022 SHALL drive mem_gnt_o[i] = mem_req_i[i] combinationally in ACTIVE and drive it to 0 in SLEEP and WAKE.
REQ-023 SHALL access macro i only on mem_req_i[i] & mem_gnt_o[i]; the macro request SHALL be forced to 0 otherwise.
REQ-024 SHALL pulse mem_rvalid_o[i] for one cycle exactly MemLatency cycles after each granted read, with valid data on mem_rdata_o[i] in that cycle.
REQ-025 SHALL NOT assert mem_rvalid_o for granted writes; byte-masked writes SHALL update only the enabled bytes.
REQ-026 SHALL sustain back-to-back granted accesses at one per cycle per bank, returning rvalid in issue order.
REQ-027 SHALL advance pipeline stages unconditionally; there is no backpressure.
REQ-028 SHALL, in ACTIVE, increment a saturating idle counter in each cycle that has no request and no read in flight, and clear it otherwise.
REQ-029 SHALL go from ACTIVE to SLEEP when the idle counter reaches IdleCycles, sleep_en_i = 1 and IdleCycles != 0.
REQ-030 SHALL go from SLEEP to WAKE when mem_req_i[i] = 1 or sleep_en_i = 0, loading a wake counter with WakeCycles.
REQ-031 SHALL decrement the wake counter in each WAKE cycle and enter ACTIVE when it reaches 0, with the idle counter cleared.
REQ-032 SHALL let a request held high through SLEEP and WAKE be granted in the first ACTIVE cycle, i.e. WakeCycles+1 cycles after the SLEEP-to-WAKE transition.
REQ-033 SHALL NOT enter SLEEP while any read is in flight; the wake sequence SHALL complete even if sleep_en_i rises during WAKE.
REQ-034 SHALL keep SRAM contents across SLEEP, which acts as retention.

Reset
REQ-035 SHALL, while rst_ni = 0, asynchronously place all banks in ACTIVE and clear the idle counters, wake counters, pipeline valid bits and pipeline data registers.
REQ-036 SHALL hold mem_gnt_o = mem_req_i, mem_rvalid_o = 0, mem_rdata_o = 0 (registered stages) and bank_sleep_o = 0 during and after reset.
REQ-037 SHALL discard any in-flight reads when reset is asserted mid-operation, producing no rvalid after release; SRAM contents are undefined after reset.

Verification
REQ-038 SHALL be covered by a bench that writes 0xDEAD_BEEF_0123_4567 with be = 0xFF to bank 3 at address 5, then reads it with MemLatency = 3 -> rvalid[3] 3 cycles after the read grant, with matching data.
REQ-039 SHALL be covered by a bench that writes be = 0x0F with data all-ones over 0 and reads back -> data 0x0000_0000_FFFF_FFFF.
REQ-040 SHALL be covered by a bench that sets IdleCycles = 16 and sleep_en_i = 1 with no traffic for 16 cycles, then holds a request -> bank_sleep_o = 1, grant after WakeCycles+1 = 5 cycles, and contents retained.
REQ-041 SHALL be covered by a bench that issues 8 back-to-back reads to one bank -> 8 consecutive rvalid pulses in order, with no sleep entry.
REQ-042 SHALL be covered by a bench that deasserts sleep_en_i while a bank is in SLEEP -> WAKE then ACTIVE without any request, and one with IdleCycles = 0 -> never sleeps.
REQ-043 SHALL be covered by a bench that asserts reset with 2 reads in flight -> no rvalid after release, and all outputs at reset values.
